// File: rtl/nco_core.sv
`default_nettype none
// ============================================================================
// Module   : nco_core
// Purpose  : 32-bit phase-accumulator NCO with saw/triangle/square shaping
//            through a 3-stage pipeline. Optional LFSR phase dither is
//            enabled by defining NCO_DITHER_EN.
// Revision : 1.0  initial release
// ============================================================================
module nco_core #(
    parameter int OUT_W    = 16,
    parameter int DITHER_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              nco_reset,
    input  logic [31:0]       nco_ctrl,
    input  logic [15:0]       phase_offset,
    input  logic [1:0]        wave_sel,
    output logic [OUT_W-1:0]  sample,
    output logic              sample_valid,
    output logic              cycle_start
);

    // Stage 1: accumulator
    logic [31:0]      acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             v1_q, v1_d;
    // Stage 2: phase
    logic [15:0]      ph_q, ph_d;
    logic [1:0]       wsel_q, wsel_d;
    logic             v2_q, v2_d;
    logic             c2_q, c2_d;
    // Stage 3: outputs
    logic [OUT_W-1:0] sample_q, sample_d;
    logic             valid_q, valid_d;
    logic             cs_q, cs_d;

    logic [31:0]      dith;
    logic [14:0]      tri_t;
    logic [15:0]      r;

`ifdef NCO_DITHER_EN
    logic [15:0]      lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        dith   = 32'(lfsr_q[DITHER_W-1:0]);
    end

    // The LFSR free-runs; nco_reset does not restart the dither sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= 16'hACE1;
        else        lfsr_q <= lfsr_d;
    end
`else
    assign dith = 32'd0;
`endif

    always_comb begin
        if (nco_reset) begin
            {carry_d, acc_d} = 33'd0;
            v1_d             = 1'b0;
        end else begin
            {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, nco_ctrl};
            v1_d             = 1'b1;
        end

        ph_d   = 16'((acc_q + dith) >> 16) + phase_offset;
        wsel_d = wave_sel;
        v2_d   = v1_q;
        c2_d   = carry_q;

        tri_t = ph_q[15] ? ~ph_q[14:0] : ph_q[14:0];
        case (wsel_q)
            2'b00:   r = ph_q ^ 16'h8000;
            2'b01:   r = {tri_t, 1'b0} ^ 16'h8000;
            2'b10:   r = ph_q[15] ? 16'h7FFF : 16'h8000;
            default: r = 16'h0000;
        endcase

        sample_d = v2_q ? OUT_W'(r >> (16 - OUT_W)) : '0;
        valid_d  = v2_q;
        cs_d     = v2_q & c2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= 32'd0;
            carry_q  <= 1'b0;
            v1_q     <= 1'b0;
            ph_q     <= 16'd0;
            wsel_q   <= 2'd0;
            v2_q     <= 1'b0;
            c2_q     <= 1'b0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            cs_q     <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            v1_q     <= v1_d;
            ph_q     <= ph_d;
            wsel_q   <= wsel_d;
            v2_q     <= v2_d;
            c2_q     <= c2_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            cs_q     <= cs_d;
        end
    end

    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign cycle_start  = cs_q;

endmodule
`default_nettype wire

// File: doc/nco_core.md
Name: nco_core

Overview:
- Numerically controlled oscillator that consumes the nco_ctrl and nco_reset pair driven by the chirp/sweep controller.
- Integrates the frequency tuning word into a 32-bit phase accumulator and applies a phase offset.
- Produces a selectable saw, triangle or square sample stream through a 3-stage pipeline.
- Sits between the sweep controller and the DAC output formatter.

Parameters:
- OUT_W, 16, sample width in bits (2..16); sample is the top OUT_W bits of the 16-bit stage-3 result.
- DITHER_W, 12, number of LFSR bits added below the phase truncation point (1..16); used only with NCO_DITHER_EN.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- nco_reset  in  1  synchronous accumulator clear and output blanking, from the sweep controller
- nco_ctrl  in  32  frequency tuning word, unsigned, phase increment per clk
- phase_offset  in  16  phase offset added to the truncated phase, mod 2^16
- wave_sel  in  2  waveform select: 00 saw, 01 triangle, 10 square, 11 midscale (zero)
- sample  out  OUT_W  two's-complement waveform sample
- sample_valid  out  1  high when sample derives from a non-reset accumulator cycle
- cycle_start  out  1  one-cycle pulse aligned with the sample following an accumulator wrap

Behaviour:
- Reset (rst_n low, async) clears the following; the pipeline is empty after release.
  - acc, stage-2 phase and all pipeline registers to 0.
  - sample to 0, sample_valid to 0, cycle_start to 0.
- Stage 1 (accumulator):
  - If nco_reset: acc <= 0, carry <= 0, v1 <= 0.
  - Else: {carry, acc} <= acc + nco_ctrl (33-bit sum, wrap mod 2^32), v1 <= 1.
- Stage 2 (phase):
  - ph <= (acc + dith)[31:16] + phase_offset, mod 2^16. dith = 0 unless NCO_DITHER_EN is defined.
  - wave_sel and phase_offset are sampled here.
  - v2 <= v1, c2 <= carry.
- Stage 3 (shaping), registered into the outputs:
  - saw: r = ph ^ 16'h8000.
  - triangle: t = ph[15] ? ~ph[14:0] : ph[14:0]; r = {t,1'b0} ^ 16'h8000.
  - square: r = ph[15] ? 16'h7FFF : 16'h8000.
  - 11: r = 0.
  - sample <= v2 ? r[15:16-OUT_W] : 0.
  - sample_valid <= v2.
  - cycle_start <= v2 & c2.
- Latency:
  - nco_ctrl to acc: 1 clk.
  - acc to sample: 2 clk.
  - wave_sel and phase_offset to sample: 1 clk after the stage-2 sample edge.
- nco_reset held N cycles: acc stays 0, and sample_valid is low for N cycles starting 3 clk after nco_reset first rises.
  - The first valid sample after nco_reset falls has ph = (nco_ctrl + dith)[31:16] + offset.
  - The zero phase itself is never output as valid.
- nco_ctrl = 0 with nco_reset low: acc holds; output is constant and valid; no cycle_start.
- Wrap: carry = 1 exactly when the 33-bit add overflows. An exact landing on 0 also counts, e.g. 0xC0000000 + 0x40000000.
- nco_ctrl changing every cycle (sweep): each value is applied on the edge it is present; no internal holding.
- rst_n asserted mid-operation: outputs go to their reset values immediately (async). Pipeline refill takes 3 clk after release.

Optional Feature:
- Macro: NCO_DITHER_EN.
- Defined:
  - 16-bit Galois LFSR: right shift; if the shifted-out lsb is 1, XOR with 16'hB400. Seed 16'hACE1 on rst_n.
  - Advances every clk regardless of nco_reset.
  - dith = zero-extended lfsr[DITHER_W-1:0], added to acc before truncation in stage 2.
- Undefined: no LFSR registers; dith = 0; bit-exact truncation.

Test Plan:
- rst_n low 5 clk, random inputs -> sample=0, sample_valid=0, cycle_start=0 throughout; first valid sample 3 clk after rst_n rises.
- nco_ctrl=32'h40000000, wave_sel=00, offset=0 -> valid samples cycle 16'hC000, 16'h0000, 16'h4000, 16'h8000; cycle_start=1 only on the 16'h8000 sample.
- Same stimulus, wave_sel=01 -> samples cycle 16'h0000, 16'h7FFE, 16'hFFFE, 16'h8000.
- nco_ctrl=0, wave_sel=10, phase_offset=16'h8000 -> sample constant 16'h7FFF; with offset 0 -> 16'h8000; cycle_start never pulses.
- Running at 32'h40000000, nco_reset high 4 clk -> sample_valid low 4 clk starting 3 clk after assertion, sample=0 while low; first valid sample after release is 16'hC000 (saw).
- NCO_DITHER_EN defined, nco_ctrl=32'h00010000, offset=0, saw -> ph increments by exactly 1 per clk (no dither carry); LFSR sequence starts 16'hACE1, 16'hE270.
